q_measure: RTL

Measurement responder paired with the `bisection` controller. It takes the controller's `i_ref` and drives it to the current-reference DAC. After a fixed settling time it averages a power-of-two number of ADC quality-factor samples. It then returns `q_measured` together with a level `ready` that tells the controller the value belongs to the current `i_ref`.

---
 rtl/q_measure.sv | 127 ++++++++++++
 1 files changed

// File: rtl/q_measure.sv
// q_measure: drives the DAC with the requested reference code, waits out
// the settling time, then averages a power-of-two block of ADC Q samples.
module q_measure #(
  parameter int unsigned BUS_WIDTH     = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic [BUS_WIDTH-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [BUS_WIDTH-1:0] dac_code,
  output logic [BUS_WIDTH-1:0] q_measured,
  output logic                 ready
);

  localparam int unsigned SCW = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned SMW = AVG_LOG2 + 1;
  localparam int unsigned AW  = BUS_WIDTH + AVG_LOG2;

  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SMW-1:0] SMP_LAST    = SMW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACQUIRE,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] dac_q, dac_d;
  logic [BUS_WIDTH-1:0] qm_q, qm_d;
  logic                 rdy_q, rdy_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [SMW-1:0]       smp_q, smp_d;
  logic [AW-1:0]        acc_q, acc_d;

  logic [AW-1:0]        sum;
  logic                 mismatch;

  // Accumulator holds at most N-1 samples here, so adding one more fits AW.
  assign sum      = acc_q + AW'(adc_data);
  assign mismatch = (i_ref != dac_q);

  // Next-state and datapath update; priority is enable, then mismatch.
  always_comb begin
    state_d  = state_q;
    dac_d    = dac_q;
    qm_d     = qm_q;
    rdy_d    = rdy_q;
    settle_d = settle_q;
    smp_d    = smp_q;
    acc_d    = acc_q;

    if (!enable) begin
      state_d = IDLE;
      rdy_d   = 1'b0;
    end else if (state_q != IDLE && mismatch) begin
      state_d  = SETTLE;
      dac_d    = i_ref;
      settle_d = '0;
      rdy_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          dac_d    = i_ref;
          settle_d = '0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          settle_d = settle_q + SCW'(1);
          if (settle_q == SETTLE_LAST) begin
            state_d = ACQUIRE;
            acc_d   = '0;
            smp_d   = '0;
          end
        end
        ACQUIRE: begin
          if (adc_valid) begin
            acc_d = sum;
            smp_d = smp_q + SMW'(1);
            if (smp_q == SMP_LAST) begin
              qm_d    = sum[AVG_LOG2 +: BUS_WIDTH];
              rdy_d   = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dac_q    <= '0;
      qm_q     <= '0;
      rdy_q    <= 1'b0;
      settle_q <= '0;
      smp_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      qm_q     <= qm_d;
      rdy_q    <= rdy_d;
      settle_q <= settle_d;
      smp_q    <= smp_d;
      acc_q    <= acc_d;
    end
  end

  assign dac_code   = dac_q;
  assign q_measured = qm_q;
  assign ready      = rdy_q;

endmodule
